// File: rtl/sim_uart_in_responder_if.sv
// Handshake bundle between the host push side, SimTop's UART input pins and the responder.
interface sim_uart_in_responder_if;
  logic       push_valid;
  logic [7:0] push_ch;
  logic       push_ready;
  logic       io_uart_in_valid;
  logic [7:0] io_uart_in_ch;

  modport master (
    output push_valid,
    output push_ch,
    output io_uart_in_valid,
    input  push_ready,
    input  io_uart_in_ch
  );

  modport slave (
    input  push_valid,
    input  push_ch,
    input  io_uart_in_valid,
    output push_ready,
    output io_uart_in_ch
  );
endinterface

// File: rtl/sim_uart_in_responder.sv
// UART input responder: FIFO of host-pushed characters answered with zero latency on SoC reads.
// Optional echo of consumed characters is enabled by defining SIM_UART_IN_ECHO_EN.
module sim_uart_in_responder #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  EMPTY_CH = 8'hff
) (
  input  logic                     clock,
  input  logic                     reset,
  sim_uart_in_responder_if.slave   bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              rd_count,
  output logic [31:0]              empty_rd_count,
  output logic                     echo_valid,
  output logic [7:0]               echo_ch
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [31:0] rd_count_q, empty_rd_count_q;

  logic       empty, full;
  logic       push_fire, pop_fire, empty_rd;
  logic [7:0] head;

  // Extra pointer MSB separates full (same slot, other lap) from empty.
  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    push_fire = bus.push_valid && !full;
    pop_fire  = bus.io_uart_in_valid && !empty;
    empty_rd  = bus.io_uart_in_valid && empty;
    head      = mem_q[rptr_q[AW-1:0]];
  end

  assign bus.push_ready    = !full;
  assign bus.io_uart_in_ch = empty ? EMPTY_CH : head;
  assign level             = wptr_q - rptr_q;
  assign rd_count          = rd_count_q;
  assign empty_rd_count    = empty_rd_count_q;

  // Storage is deliberately not reset; the empty flag masks stale contents.
  always_ff @(posedge clock) begin
    if (push_fire && !reset) begin
      mem_q[wptr_q[AW-1:0]] <= bus.push_ch;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q           <= '0;
      rptr_q           <= '0;
      rd_count_q       <= '0;
      empty_rd_count_q <= '0;
    end else begin
      if (push_fire) wptr_q <= wptr_q + 1'b1;
      if (pop_fire) begin
        rptr_q <= rptr_q + 1'b1;
        if (rd_count_q != 32'hffff_ffff) rd_count_q <= rd_count_q + 32'd1;
      end
      if (empty_rd && empty_rd_count_q != 32'hffff_ffff) begin
        empty_rd_count_q <= empty_rd_count_q + 32'd1;
      end
    end
  end

`ifdef SIM_UART_IN_ECHO_EN
  logic       echo_valid_q;
  logic [7:0] echo_ch_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      echo_valid_q <= 1'b0;
      echo_ch_q    <= 8'h00;
    end else begin
      echo_valid_q <= pop_fire;
      if (pop_fire) echo_ch_q <= head;
    end
  end

  assign echo_valid = echo_valid_q;
  assign echo_ch    = echo_ch_q;
`else
  assign echo_valid = 1'b0;
  assign echo_ch    = 8'h00;
`endif

endmodule

// File: tb/tb_sim_uart_in_responder.sv
// Directed self-checking bench for sim_uart_in_responder (DEPTH = 16, EMPTY_CH = 8'hff).
module tb_sim_uart_in_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  level;
  logic [31:0] rd_count, empty_rd_count;
  logic        echo_valid;
  logic [7:0]  echo_ch;
  int          n_cmp = 0;
  int          n_err = 0;

  sim_uart_in_responder_if bus ();

  sim_uart_in_responder #(
    .DEPTH    (16),
    .EMPTY_CH (8'hff)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .level          (level),
    .rd_count       (rd_count),
    .empty_rd_count (empty_rd_count),
    .echo_valid     (echo_valid),
    .echo_ch        (echo_ch)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic idle_inputs();
    bus.push_valid       = 1'b0;
    bus.push_ch          = 8'h00;
    bus.io_uart_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] ch);
    @(negedge clock);
    idle_inputs();
    bus.push_valid = 1'b1;
    bus.push_ch    = ch;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (bus.push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready got %b want 1", bus.push_ready); end
    n_cmp++; if (bus.io_uart_in_ch !== 8'hff) begin n_err++; $display("FAIL reset_ch got %h want ff", bus.io_uart_in_ch); end
    n_cmp++; if (rd_count !== 32'd0 || empty_rd_count !== 32'd0) begin
      n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", rd_count, empty_rd_count);
    end
    n_cmp++; if (echo_valid !== 1'b0 || echo_ch !== 8'h00) begin
      n_err++; $display("FAIL reset_echo got %b/%h want 0/00", echo_valid, echo_ch);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.io_uart_in_ch !== 8'hff) begin n_err++; $display("FAIL empty_read_ch got %h want ff", bus.io_uart_in_ch); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (empty_rd_count !== 32'd1 || rd_count !== 32'd0 || level !== 5'd0) begin
      n_err++; $display("FAIL empty_read_state got erd=%0d rd=%0d lvl=%0d want 1 0 0", empty_rd_count, rd_count, level);
    end
  endtask

  task automatic test_ordered_drain();
    logic [7:0] exp [4];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43; exp[3] = 8'hff;
    do_reset();
    push_one(8'h41);
    push_one(8'h42);
    push_one(8'h43);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle_inputs();
      bus.io_uart_in_valid = 1'b1;
      #1;
      n_cmp++; if (bus.io_uart_in_ch !== exp[i]) begin
        n_err++; $display("FAIL drain_ch[%0d] got %h want %h", i, bus.io_uart_in_ch, exp[i]);
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (rd_count !== 32'd3 || empty_rd_count !== 32'd1) begin
      n_err++; $display("FAIL drain_counts got %0d/%0d want 3/1", rd_count, empty_rd_count);
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) push_one(8'(i));
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (level !== 5'd16 || bus.push_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_full got lvl=%0d rdy=%b want 16 0", level, bus.push_ready);
    end
    // 17th push must be held off while full.
    bus.push_valid = 1'b1;
    bus.push_ch    = 8'haa;
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL fill_overflow_level got %0d want 16", level); end
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.io_uart_in_ch !== 8'h00) begin n_err++; $display("FAIL fill_first_read got %h want 00", bus.io_uart_in_ch); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (bus.push_ready !== 1'b1 || level !== 5'd15) begin
      n_err++; $display("FAIL fill_reopen got rdy=%b lvl=%0d want 1 15", bus.push_ready, level);
    end
    bus.push_valid = 1'b1;
    bus.push_ch    = 8'h10;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      idle_inputs();
      bus.io_uart_in_valid = 1'b1;
      #1;
      n_cmp++; if (bus.io_uart_in_ch !== 8'(i + 1)) begin
        n_err++; $display("FAIL wrap_ch[%0d] got %h want %h", i, bus.io_uart_in_ch, 8'(i + 1));
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (level !== 5'd0 || rd_count !== 32'd17 || bus.io_uart_in_ch !== 8'hff) begin
      n_err++; $display("FAIL wrap_end got lvl=%0d rd=%0d ch=%h want 0 17 ff", level, rd_count, bus.io_uart_in_ch);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_one(8'h50);
    push_one(8'h51);
    @(negedge clock);
    idle_inputs();
    bus.push_valid       = 1'b1;
    bus.push_ch          = 8'h52;
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.io_uart_in_ch !== 8'h50) begin n_err++; $display("FAIL simul_head got %h want 50", bus.io_uart_in_ch); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (level !== 5'd2) begin n_err++; $display("FAIL simul_level got %0d want 2", level); end

    do_reset();
    bus.push_valid       = 1'b1;
    bus.push_ch          = 8'h60;
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.io_uart_in_ch !== 8'hff) begin n_err++; $display("FAIL simul_empty_ch got %h want ff", bus.io_uart_in_ch); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (level !== 5'd1 || empty_rd_count !== 32'd1 || rd_count !== 32'd0) begin
      n_err++; $display("FAIL simul_empty_state got lvl=%0d erd=%0d rd=%0d want 1 1 0", level, empty_rd_count, rd_count);
    end
    n_cmp++; if (bus.io_uart_in_ch !== 8'h60) begin n_err++; $display("FAIL simul_stored got %h want 60", bus.io_uart_in_ch); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) push_one(8'h70 + 8'(i));
    @(negedge clock);
    idle_inputs();
    bus.io_uart_in_valid = 1'b1;
    @(negedge clock);
    idle_inputs();
    reset                = 1'b1;
    bus.push_valid       = 1'b1;
    bus.push_ch          = 8'h99;
    bus.io_uart_in_valid = 1'b1;
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    n_cmp++; if (level !== 5'd0 || rd_count !== 32'd0 || empty_rd_count !== 32'd0) begin
      n_err++; $display("FAIL midreset_state got lvl=%0d rd=%0d erd=%0d want 0 0 0", level, rd_count, empty_rd_count);
    end
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.io_uart_in_ch !== 8'hff) begin n_err++; $display("FAIL midreset_read got %h want ff", bus.io_uart_in_ch); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_echo();
    logic       exp_v;
    logic [7:0] exp_c;
`ifdef SIM_UART_IN_ECHO_EN
    exp_v = 1'b1;
    exp_c = 8'h0a;
`else
    exp_v = 1'b0;
    exp_c = 8'h00;
`endif
    do_reset();
    push_one(8'h0a);
    @(negedge clock);
    idle_inputs();
    bus.io_uart_in_valid = 1'b1;
    #1;
    n_cmp++; if (echo_valid !== 1'b0) begin n_err++; $display("FAIL echo_early got %b want 0", echo_valid); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (echo_valid !== exp_v || echo_ch !== exp_c) begin
      n_err++; $display("FAIL echo_pulse got %b/%h want %b/%h", echo_valid, echo_ch, exp_v, exp_c);
    end
    // Empty read on this cycle must not echo.
    bus.io_uart_in_valid = 1'b1;
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (echo_valid !== 1'b0) begin n_err++; $display("FAIL echo_single got %b want 0", echo_valid); end
    @(negedge clock);
    #1;
    n_cmp++; if (echo_valid !== 1'b0) begin n_err++; $display("FAIL echo_empty_read got %b want 0", echo_valid); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_empty_read();
    test_ordered_drain();
    test_fill_wrap();
    test_simultaneous();
    test_reset_midstream();
    test_echo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
